piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in serial-out transmitter. It accepts a WIDTH-bit word through a valid/ready handshake and shifts the word out one bit per clock, LSB first, on `ser_out`. `frame_out` qualifies each transmitted bit, and `done_out` pulses on the last bit. It is the sending end of the serial links whose receiving end is a load-enabled SIPO shift register: `frame_out` drives the receiver's load/enable, and `ser_out` drives its serial input.

## Interface
Parameters:
- `WIDTH`, default 4: word width in bits; legal range 2..32.
- `GAP_CYCLES`, default 1: idle cycles (frame low) forced after each frame; legal range 0..15.

Ports:
- `clk`  input  1  rising-edge clock; single clock domain.
- `rst`  input  1  synchronous, active-high reset.
- `data_in`  input  WIDTH  parallel word; sampled only on an accepted transfer.
- `valid_in`  input  1  upstream asserts that `data_in` is valid.
- `ready_out`  output  1  block can accept a word this cycle.
- `ser_out`  output  1  serial data, LSB first.
- `frame_out`  output  1  high exactly while `ser_out` carries a valid bit.
- `done_out`  output  1  one-cycle pulse coincident with the last bit of a frame.

## Operation
- All outputs are registered.
- **Transfer rule:** a transfer is accepted on a rising edge where `valid_in` = 1, `ready_out` = 1 and `rst` = 0.
  - `data_in` is captured into a WIDTH-bit shift register.
  - `valid_in` is ignored whenever `ready_out` = 0; no buffering or queuing.
- **State machine:** IDLE, SHIFT, GAP.
- **IDLE:**
  - `ready_out` = 1, `frame_out` = 0, `ser_out` = 0.
  - An accepted transfer moves to SHIFT and loads the bit counter with 0.
- **SHIFT:**
  - `frame_out` = 1 and `ser_out` = `word[count]`.
  - The counter increments each cycle.
  - When count = WIDTH-1, `done_out` = 1 that cycle. The next state is GAP if GAP_CYCLES > 0, else IDLE.
  - `ready_out` = 0 throughout.
- **GAP:**
  - `frame_out` = 0, `ser_out` = 0, `ready_out` = 0.
  - The state lasts exactly GAP_CYCLES cycles (gap counter), then goes to IDLE.
- **Bit counter:** clog2(WIDTH) bits wide. It never wraps mid-frame; exactly WIDTH bits are sent per frame, never more or fewer.
- **Word capture:** the captured word is held stable for the whole frame. Changes to `data_in` after acceptance have no effect.
- **Reset:**
  - While `rst` = 1: state = IDLE, counters = 0, shift register = 0, `ser_out` = 0, `frame_out` = 0, `done_out` = 0, `ready_out` = 0.
  - `ready_out` rises in the first cycle after `rst` deasserts.
- **Reset mid-frame:** the frame is aborted, and no `done_out` is produced for the partial frame. `rst` has priority over an acceptance in the same cycle.

## Timing
- Acceptance on edge k (end of cycle k). Bit i (i = 0..WIDTH-1) appears on `ser_out` in cycle k+1+i with `frame_out` = 1.
- `done_out` is high only in cycle k+WIDTH.
- Gap cycles are k+WIDTH+1 .. k+WIDTH+GAP_CYCLES.
- `ready_out` = 1 again in cycle k+WIDTH+GAP_CYCLES+1.
- Throughput: one word per WIDTH+GAP_CYCLES+1 cycles with `valid_in` held high. The default is 6 cycles per 4-bit word.
- Latency from acceptance edge to first bit: 1 cycle.
- Receiver contract: a WIDTH-bit LSB-first deserializer that shifts on every clock where `frame_out` = 1 holds the original word after the cycle in which `done_out` = 1.

## Test plan
- **Reset:** `rst` = 1 for 3 cycles with `valid_in` = 1 and `data_in` = 4'hF.
  - All outputs are 0 throughout and no frame starts.
  - `ready_out` = 1 on the first cycle after release.
- **Single word:** 4'b1011 accepted at edge k.
  - `ser_out` = 1,1,0,1 in cycles k+1..k+4.
  - `frame_out` is high for exactly those 4 cycles; `done_out` is high only at k+4.
  - `ready_out` returns at k+6.
- **Back-to-back:** `valid_in` held high with 4'hA then 4'h5.
  - Bits 0,1,0,1 are sent, then one cycle with `frame_out` low, then 1,0,1,0.
  - The second frame occupies cycles k+7..k+10.
- **Busy stimulus:** toggle `data_in` and pulse `valid_in` during SHIFT and GAP.
  - The serial stream is unchanged and no extra frame is produced.
  - The next word is accepted only once `ready_out` = 1.
- **Reset mid-frame:** assert `rst` after 2 bits of 4'b0110.
  - Next cycle: `frame_out` = 0, `ser_out` = 0, and no `done_out`.
  - After release, a new word 4'h9 transmits cleanly as 1,0,0,1.
- **Loopback:** WIDTH=8, GAP_CYCLES=0, random words into an 8-bit LSB-first deserializer enabled by `frame_out`.
  - The recovered word equals the sent word for 1000 frames.
  - `ready_out` reasserts in cycle k+9.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter.
// Accepts a WIDTH-bit word over valid/ready and sends it LSB first, one bit
// per clock, with frame_out qualifying each bit and done_out on the last bit.
// GAP_CYCLES idle cycles (frame low) are enforced between frames.
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             ser_out,
  output logic             frame_out,
  output logic             done_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  // Only meaningful when GAP_CYCLES > 0; the GAP state is unreachable otherwise.
  localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_s;
  logic [3:0]       gap_r;
  logic [3:0]       gap_s;
  logic [WIDTH-1:0] word_r;
  logic [WIDTH-1:0] word_s;
  logic             accept_s;
  logic             ready_s;
  logic             frame_s;
  logic             ser_s;
  logic             done_s;

  // Next-state, counter and captured-word logic.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    gap_s    = gap_r;
    word_s   = word_r;
    // ready_out is the registered view of the IDLE state, so it gates acceptance.
    accept_s = valid_in & ready_out;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = S_SHIFT;
          cnt_s   = {CW{1'b0}};
          word_s  = data_in;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cnt_r == LAST_BIT) begin
          cnt_s = {CW{1'b0}};
          gap_s = 4'd0;
          if (GAP_CYCLES > 0) begin
            state_s = S_GAP;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CW'(1'b1);
        end
      end
      S_GAP: begin
        if (gap_r == GAP_LAST) begin
          gap_s   = 4'd0;
          state_s = S_IDLE;
        end else begin
          gap_s = gap_r + 4'd1;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = {CW{1'b0}};
        gap_s   = 4'd0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so that
  // the registered outputs line up with the state they describe.
  always_comb begin
    ready_s = (state_s == S_IDLE);
    frame_s = (state_s == S_SHIFT);
    if (frame_s) begin
      ser_s  = word_s[cnt_s];
      done_s = (cnt_s == LAST_BIT);
    end else begin
      ser_s  = 1'b0;
      done_s = 1'b0;
    end
  end

  // State, counters, word and registered outputs; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CW{1'b0}};
      gap_r     <= 4'd0;
      word_r    <= {WIDTH{1'b0}};
      ready_out <= 1'b0;
      frame_out <= 1'b0;
      ser_out   <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      gap_r     <= gap_s;
      word_r    <= word_s;
      ready_out <= ready_s;
      frame_out <= frame_s;
      ser_out   <= ser_s;
      done_out  <= done_s;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: directed tests on a 4-bit / 1-gap
// instance, plus an 8-bit / 0-gap instance looped into a SIPO deserializer.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // Instance A: defaults (WIDTH=4, GAP_CYCLES=1)
  logic [3:0] a_data = 4'h0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_ser, a_frame, a_done;

  // Instance B: loopback (WIDTH=8, GAP_CYCLES=0)
  logic [7:0] b_data = 8'h00;
  logic       b_valid = 1'b0;
  logic       b_ready, b_ser, b_frame, b_done;
  logic [7:0] b_sr = 8'h00;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  exp_t       qa[$];
  logic [7:0] qb[$];

  piso_serializer #(.WIDTH(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_data), .valid_in(a_valid),
    .ready_out(a_ready), .ser_out(a_ser), .frame_out(a_frame), .done_out(a_done)
  );

  piso_serializer #(.WIDTH(8), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_data), .valid_in(b_valid),
    .ready_out(b_ready), .ser_out(b_ser), .frame_out(b_frame), .done_out(b_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_a(input logic [3:0] w);
    for (int i = 0; i < 4; i++) qa.push_back('{b: w[i], last: (i == 3)});
  endtask

  // Call from just after a rising edge; returns the cycle stamp of the accept edge.
  task automatic send_a(input logic [3:0] w, output int acc);
    int n;
    n = 0;
    a_valid = 1'b1;
    a_data  = w;
    @(negedge clk);
    while (!a_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) begin
      chk("send_a_timeout", 32'd0, 32'd1);
      a_valid = 1'b0;
      acc = -1;
    end else begin
      push_a(w);
      @(posedge clk);
      #1;
      acc = cyc;
      a_valid = 1'b0;
    end
  endtask

  // Monitor A: every bit on the wire must match the next expected bit.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_frame) begin
        if (qa.size() == 0) begin
          chk("a_extra_bit", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = qa.pop_front();
          chk("a_ser", {31'd0, a_ser}, {31'd0, e.b});
          chk("a_done", {31'd0, a_done}, {31'd0, e.last});
        end
      end else begin
        chk("a_done_idle", {31'd0, a_done}, 32'd0);
        chk("a_ser_idle", {31'd0, a_ser}, 32'd0);
      end
    end
  end

  // Receiver model for B: LSB-first SIPO enabled by frame_out.
  always @(posedge clk) begin
    if (b_frame) b_sr <= {b_ser, b_sr[7:1]};
  end

  // Monitor B: the recovered word after the done cycle must match.
  always @(negedge clk) begin
    if (!rst && b_frame) begin
      if (qb.size() == 0) begin
        chk("b_extra_frame", 32'd1, 32'd0);
      end else if (b_done) begin
        chk("lb_word", {24'd0, b_ser, b_sr[7:1]}, {24'd0, qb.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int k1, k2, prev, n;

    // ---- Reset: 3 cycles with valid high and data F ----
    rst = 1'b1;
    a_valid = 1'b1;
    a_data = 4'hF;
    b_valid = 1'b1;
    b_data = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", {31'd0, a_ready}, 32'd0);
      chk("rst_frame", {31'd0, a_frame}, 32'd0);
      chk("rst_ser", {31'd0, a_ser}, 32'd0);
      chk("rst_done", {31'd0, a_done}, 32'd0);
      chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, a_ready}, 32'd1);
    chk("post_rst_frame", {31'd0, a_frame}, 32'd0);
    chk("post_rst_b_frame", {31'd0, b_frame}, 32'd0);
    a_valid = 1'b0;
    b_valid = 1'b0;

    // ---- Single word 4'b1011 ----
    @(posedge clk);
    #1;
    send_a(4'b1011, k1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("single_frame", {31'd0, a_frame}, (i <= 4) ? 32'd1 : 32'd0);
      chk("single_done", {31'd0, a_done}, (i == 4) ? 32'd1 : 32'd0);
      chk("single_ready", {31'd0, a_ready}, (i == 6) ? 32'd1 : 32'd0);
    end

    // ---- Back-to-back: A then 5 with valid held ----
    @(posedge clk);
    #1;
    a_valid = 1'b1;
    a_data = 4'hA;
    push_a(4'hA);
    push_a(4'h5);
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_ready_seen", {31'd0, a_ready}, 32'd1);
    @(posedge clk);
    #1;
    a_data = 4'h5;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("b2b_frame", {31'd0, a_frame},
          ((i <= 4) || (i >= 7)) ? 32'd1 : 32'd0);
      chk("b2b_done", {31'd0, a_done}, ((i == 4) || (i == 10)) ? 32'd1 : 32'd0);
      if (i == 7) a_valid = 1'b0;
    end
    repeat (3) @(negedge clk);

    // ---- Busy stimulus during SHIFT and GAP ----
    @(posedge clk);
    #1;
    send_a(4'b1100, k1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("busy_ready", {31'd0, a_ready}, 32'd0);
      a_data = 4'(i * 5);
      a_valid = (i % 2 == 1) && (i < 5);
    end
    @(negedge clk);
    chk("busy_ready_back", {31'd0, a_ready}, 32'd1);
    @(posedge clk);
    #1;
    send_a(4'h3, k2);
    chk("busy_next_accept", k2 - k1, 32'd7);
    repeat (8) @(negedge clk);

    // ---- Reset mid-frame ----
    @(posedge clk);
    #1;
    send_a(4'b0110, k1);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    qa.delete();
    @(negedge clk);
    chk("midrst_frame", {31'd0, a_frame}, 32'd0);
    chk("midrst_ser", {31'd0, a_ser}, 32'd0);
    chk("midrst_done", {31'd0, a_done}, 32'd0);
    @(negedge clk);
    chk("midrst_done2", {31'd0, a_done}, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send_a(4'h9, k1);
    repeat (8) @(negedge clk);

    // ---- Loopback on B: 1000 random words, valid held ----
    @(posedge clk);
    #1;
    b_valid = 1'b1;
    b_data = 8'($urandom);
    prev = -1;
    for (int f = 0; f < 1000; f++) begin
      n = 0;
      @(negedge clk);
      while (!b_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!b_ready) begin
        chk("lb_timeout", 32'd0, 32'd1);
        break;
      end
      qb.push_back(b_data);
      @(posedge clk);
      #1;
      if (f > 0) chk("lb_period", cyc - prev, 32'd9);
      prev = cyc;
      b_data = 8'($urandom);
    end
    b_valid = 1'b0;
    repeat (20) @(negedge clk);

    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
